// File: rtl/if_fetch_queue.sv
// Fetch front end: owns the fetch PC, issues word fetches to a 1-cycle imem and queues
// {PC+4, instr} pairs for decode. Optional `IF_FETCH_STATS_EN adds FetchCount/FlushCount.
module if_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Redirect,
  input  logic [31:0] RedirectAddr,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemInstr,
  output logic [31:0] PCValue,
  output logic        Valid_out,
  input  logic        Ready_in,
  output logic [31:0] Instr_out,
  output logic [31:0] PC_out
`ifdef IF_FETCH_STATS_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] FlushCount
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   tag_q, tag_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   lastInstr_q, lastInstr_d;
  logic [31:0]   lastPc_q, lastPc_d;
  logic [31:0]   fifoInstr_q [DEPTH];
  logic [31:0]   fifoPc_q [DEPTH];

  logic [CW:0]   occupancy;
  logic          notEmpty;
  logic          issue;
  logic          push;
  logic          pop;
  logic [31:0]   redirectPc;

  // Credit rule: queued entries plus the in-flight response never exceed DEPTH,
  // so the FIFO cannot overflow and needs no full check on push.
  always_comb begin
    occupancy  = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    notEmpty   = (count_q != '0);
    issue      = Rst && !Redirect && (occupancy < DEPTH_C);
    push       = inflight_q && !Redirect;
    pop        = notEmpty && Ready_in && !Redirect;
    redirectPc = RedirectAddr & 32'hFFFF_FFFC;
  end

  always_comb begin
    pc_d        = pc_q;
    inflight_d  = inflight_q;
    tag_d       = tag_q;
    rdPtr_d     = rdPtr_q;
    wrPtr_d     = wrPtr_q;
    count_d     = count_q;
    lastInstr_d = lastInstr_q;
    lastPc_d    = lastPc_q;

    if (Redirect) begin
      pc_d       = redirectPc;
      inflight_d = 1'b0;
      rdPtr_d    = '0;
      wrPtr_d    = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        pc_d  = pc_q + 32'd4;
        tag_d = pc_q + 32'd4;
      end
      inflight_d = issue;
      if (push) wrPtr_d = wrPtr_q + PW'(1);
      if (pop)  rdPtr_d = rdPtr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end

    // Remember the head being retired so the outputs hold it while the queue is empty.
    if (notEmpty && (pop || Redirect)) begin
      lastInstr_d = fifoInstr_q[rdPtr_q];
      lastPc_d    = fifoPc_q[rdPtr_q];
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      pc_q        <= RESET_PC;
      inflight_q  <= 1'b0;
      tag_q       <= 32'h0;
      rdPtr_q     <= '0;
      wrPtr_q     <= '0;
      count_q     <= '0;
      lastInstr_q <= 32'h0;
      lastPc_q    <= 32'h0;
    end else begin
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
      tag_q       <= tag_d;
      rdPtr_q     <= rdPtr_d;
      wrPtr_q     <= wrPtr_d;
      count_q     <= count_d;
      lastInstr_q <= lastInstr_d;
      lastPc_q    <= lastPc_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      fifoInstr_q[wrPtr_q] <= IMemInstr;
      fifoPc_q[wrPtr_q]    <= tag_q;
    end
  end

`ifdef IF_FETCH_STATS_EN
  logic [31:0] fetchCount_q, fetchCount_d;
  logic [31:0] flushCount_q, flushCount_d;

  // A flush discards every queued entry plus any response still in flight.
  always_comb begin
    fetchCount_d = fetchCount_q;
    flushCount_d = flushCount_q;
    if (pop)      fetchCount_d = fetchCount_q + 32'd1;
    if (Redirect) flushCount_d = flushCount_q + 32'(occupancy);
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      fetchCount_q <= 32'h0;
      flushCount_q <= 32'h0;
    end else begin
      fetchCount_q <= fetchCount_d;
      flushCount_q <= flushCount_d;
    end
  end

  assign FetchCount = fetchCount_q;
  assign FlushCount = flushCount_q;
`endif

  assign IMemReq   = issue;
  assign IMemAddr  = pc_q;
  assign PCValue   = pc_q;
  assign Valid_out = notEmpty;
  assign Instr_out = notEmpty ? fifoInstr_q[rdPtr_q] : lastInstr_q;
  assign PC_out    = notEmpty ? fifoPc_q[rdPtr_q] : lastPc_q;

endmodule
